decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction-decode stage sitting directly upstream of register_file.
- Accepts 32-bit MIPS instructions via valid/ready and drives register_file read selectors in the accept cycle, so that value_out1/value_out2 (1-cycle registered read) align with this block's registered decode outputs.
- A 32-entry pending-write scoreboard stalls instructions whose source registers have an outstanding write; the writeback stage retires entries.

Parameters:
- SCOREBOARD_EN, 1, 1 = RAW hazard stalls enabled; 0 = never stall on hazards (bring-up only).
- RESET_NOP, 32'h0000_0000, value of held instruction after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  fetched instruction.
- instr_valid  in  1  instr valid.
- instr_ready  out  1  stage accepts instr this cycle.
- selector_out1  out  5  to register_file read port 1 (rs).
- selector_out2  out  5  to register_file read port 2 (rt).
- dec_valid  out  1  decoded instruction valid; register_file outputs are valid for it.
- dec_ready  in  1  downstream accepts decoded instruction.
- dec_opcode  out  6  instr[31:26].
- dec_funct  out  6  instr[5:0].
- dec_dest  out  5  destination register (0 if none).
- dec_writes  out  1  instruction writes a register.
- dec_imm  out  32  extended immediate or jump target field.
- dec_illegal  out  1  unsupported opcode.
- wb_valid  in  1  writeback retiring a write this cycle.
- wb_dest  in  5  register being written back.

Behaviour:
- Accept = instr_valid & instr_ready.
- instr_ready = !hazard & (!dec_valid | dec_ready).
- hazard (SCOREBOARD_EN=1) = (uses_rs & pending[rs]) | (uses_rt & pending[rt]), evaluated on instr; pending[0] is always 0.
- Selectors:
  - On accept: selector_out1 = instr[25:21], selector_out2 = instr[20:16] (combinational).
  - Otherwise: rs/rt of the held instruction, so held data is re-read every cycle.
- Decode register loads on accept. dec_valid:
  - Set on accept.
  - Cleared when dec_valid & dec_ready & !accept.
  - Stays 1 on accept while draining.
- Decode table (opcode):
  - 0x00 R-type: uses rs, rt; dest = rd; writes = 1, except funct 0x08 (jr), where writes = 0 and uses_rt = 0.
  - 0x08 addi, 0x09 addiu, 0x23 lw: uses rs; dest = rt; imm sign-extended.
  - 0x0C andi, 0x0D ori: uses rs; dest = rt; imm zero-extended.
  - 0x0F lui: dest = rt; imm = {instr[15:0], 16'h0}.
  - 0x2B sw, 0x04 beq, 0x05 bne: uses rs, rt; writes = 0; imm sign-extended.
  - 0x02 j: writes = 0. 0x03 jal: dest = 31, writes = 1. For both, imm = {6'b0, instr[25:0]}.
  - Any other opcode: dec_illegal = 1, writes = 0, no source use (never stalls).
- dest = 0 forces writes = 0.
- Scoreboard:
  - On accept with writes: pending[dest] <= 1.
  - On wb_valid: pending[wb_dest] <= 0.
  - Same register set and cleared in the same cycle: set wins.
  - Clear becomes visible the cycle after wb_valid. This extra cycle covers register_file read-before-write on the write edge.
- Reset: dec_valid=0, pending=0, held instruction = RESET_NOP, all dec_* outputs 0, instr_ready = 1 in the first cycle after reset.
- Reset mid-stall: the held instruction is discarded and all pending bits are cleared. The writeback stage is reset concurrently.

Test Plan:
- Reset, then issue addi $8,$0,5 (0x20080005) with dec_ready=1 -> next cycle dec_valid=1, dest=8, writes=1, imm=5, selectors 0/8 in the accept cycle; pending[8]=1.
- addi $8,... followed by add $9,$8,$8 -> instr_ready=0 until the cycle after wb_valid with wb_dest=8, then the add is accepted; the add's dest is 9.
- wb_valid wb_dest=8 in the same cycle as accepting a new write to $8 -> pending[8] remains 1.
- dec_ready=0 for 3 cycles with dec_valid=1 -> decode outputs and selectors held stable, instr_ready=0; dec_ready=1 with new instr_valid -> back-to-back accept, dec_valid stays 1.
- ori $4,$0,0xFFFF -> imm=0x0000FFFF. lw $4,-4($29) -> imm=0xFFFFFFFC. lui $1,0x1234 -> imm=0x12340000. jal 0x0000010 -> dest=31.
- Opcode 0x3F -> dec_illegal=1, writes=0, no stall even if pending bits are set. Writes to $0 never set pending.

Source files
------------

// File: rtl/decode_if.sv
// Handshake and data bundle between fetch, decode,
// register_file and writeback.
interface decode_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  selector_out1;
  logic [4:0]  selector_out2;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  dec_opcode;
  logic [5:0]  dec_funct;
  logic [4:0]  dec_dest;
  logic        dec_writes;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic        wb_valid;
  logic [4:0]  wb_dest;

  modport master (
    output instr, instr_valid, dec_ready,
    output wb_valid, wb_dest,
    input  instr_ready, selector_out1, selector_out2,
    input  dec_valid, dec_opcode, dec_funct,
    input  dec_dest, dec_writes, dec_imm, dec_illegal
  );

  modport slave (
    input  instr, instr_valid, dec_ready,
    input  wb_valid, wb_dest,
    output instr_ready, selector_out1, selector_out2,
    output dec_valid, dec_opcode, dec_funct,
    output dec_dest, dec_writes, dec_imm, dec_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage with register_file read steering
// and a pending-write scoreboard for RAW stalls.
module decode_stage #(
  parameter bit          SCOREBOARD_EN = 1'b1,
  parameter logic [31:0] RESET_NOP     = 32'h0000_0000
) (
  input logic   clock,
  input logic   reset,
  decode_if.slave bus
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] jimm;

  assign op   = bus.instr[31:26];
  assign fn   = bus.instr[5:0];
  assign rs   = bus.instr[25:21];
  assign rt   = bus.instr[20:16];
  assign rd   = bus.instr[15:11];
  assign sext = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign zext = {16'h0, bus.instr[15:0]};
  assign jimm = {6'b0, bus.instr[25:0]};

  logic        uses_rs;
  logic        uses_rt;
  logic [4:0]  d_dest;
  logic        d_writes;
  logic [31:0] d_imm;
  logic        d_illegal;

  always_comb begin
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    d_dest    = 5'd0;
    d_writes  = 1'b0;
    d_imm     = 32'h0;
    d_illegal = 1'b0;
    unique case (1'b1)
      op == 6'h00: begin
        uses_rs = 1'b1;
        if (fn != 6'h08) begin
          uses_rt  = 1'b1;
          d_dest   = rd;
          d_writes = 1'b1;
        end
      end
      op == 6'h08, op == 6'h09, op == 6'h23: begin
        uses_rs  = 1'b1;
        d_dest   = rt;
        d_writes = 1'b1;
        d_imm    = sext;
      end
      op == 6'h0C, op == 6'h0D: begin
        uses_rs  = 1'b1;
        d_dest   = rt;
        d_writes = 1'b1;
        d_imm    = zext;
      end
      op == 6'h0F: begin
        d_dest   = rt;
        d_writes = 1'b1;
        d_imm    = {bus.instr[15:0], 16'h0};
      end
      op == 6'h2B, op == 6'h04, op == 6'h05: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        d_imm   = sext;
      end
      op == 6'h02: begin
        d_imm = jimm;
      end
      op == 6'h03: begin
        d_dest   = 5'd31;
        d_writes = 1'b1;
        d_imm    = jimm;
      end
      default: d_illegal = 1'b1;
    endcase
    if (d_dest == 5'd0) d_writes = 1'b0;
  end

  logic [31:0] pending;
  logic        pend_rs;
  logic        pend_rt;
  logic        hazard;
  logic        accept;
  logic [4:0]  held_rs;
  logic [4:0]  held_rt;

  // $0 is never a real dependency
  assign pend_rs = pending[rs] & (rs != 5'd0);
  assign pend_rt = pending[rt] & (rt != 5'd0);
  assign hazard  = SCOREBOARD_EN &
                   ((uses_rs & pend_rs) |
                    (uses_rt & pend_rt));

  assign bus.instr_ready = !hazard &
                           (!bus.dec_valid | bus.dec_ready);
  assign accept = bus.instr_valid & bus.instr_ready;

  assign bus.selector_out1 = accept ? rs : held_rs;
  assign bus.selector_out2 = accept ? rt : held_rt;

  always_ff @(posedge clock) begin
    if (reset) begin
      held_rs         <= RESET_NOP[25:21];
      held_rt         <= RESET_NOP[20:16];
      pending         <= 32'h0;
      bus.dec_valid   <= 1'b0;
      bus.dec_opcode  <= 6'h0;
      bus.dec_funct   <= 6'h0;
      bus.dec_dest    <= 5'd0;
      bus.dec_writes  <= 1'b0;
      bus.dec_imm     <= 32'h0;
      bus.dec_illegal <= 1'b0;
    end else begin
      if (accept) begin
        held_rs         <= rs;
        held_rt         <= rt;
        bus.dec_valid   <= 1'b1;
        bus.dec_opcode  <= op;
        bus.dec_funct   <= fn;
        bus.dec_dest    <= d_dest;
        bus.dec_writes  <= d_writes;
        bus.dec_imm     <= d_imm;
        bus.dec_illegal <= d_illegal;
      end else if (bus.dec_ready) begin
        bus.dec_valid <= 1'b0;
      end
      // set is applied last so it wins over a same-cycle retire
      if (bus.wb_valid) pending[bus.wb_dest] <= 1'b0;
      if (accept && d_writes) pending[d_dest] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage.
// Inputs change 1ns after the rising edge.
module tb_decode_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  decode_if bus ();

  decode_stage #(
    .SCOREBOARD_EN (1'b1),
    .RESET_NOP     (32'h0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bus.instr       = 32'h0;
    bus.instr_valid = 1'b0;
    bus.dec_ready   = 1'b1;
    bus.wb_valid    = 1'b0;
    bus.wb_dest     = 5'd0;
    tick();
    tick();
    reset = 1'b0;
    settle();
    check("rst_valid", bus.dec_valid, 0);
    check("rst_dest", bus.dec_dest, 0);
    check("rst_imm", bus.dec_imm, 0);
    check("rst_writes", bus.dec_writes, 0);
    check("rst_ready", bus.instr_ready, 1);

    // addi $8,$0,5
    bus.instr       = 32'h2008_0005;
    bus.instr_valid = 1'b1;
    settle();
    check("addi_ready", bus.instr_ready, 1);
    check("addi_sel1", bus.selector_out1, 0);
    check("addi_sel2", bus.selector_out2, 8);
    tick();
    bus.instr_valid = 1'b0;
    settle();
    check("addi_valid", bus.dec_valid, 1);
    check("addi_dest", bus.dec_dest, 8);
    check("addi_writes", bus.dec_writes, 1);
    check("addi_imm", bus.dec_imm, 5);
    check("addi_op", bus.dec_opcode, 6'h08);

    // add $9,$8,$8 stalls on pending $8
    bus.instr       = 32'h0108_4820;
    bus.instr_valid = 1'b1;
    settle();
    check("raw_stall0", bus.instr_ready, 0);
    tick();
    check("raw_stall1", bus.instr_ready, 0);
    bus.wb_valid = 1'b1;
    bus.wb_dest  = 5'd8;
    settle();
    check("raw_wb_cycle", bus.instr_ready, 0);
    tick();
    bus.wb_valid = 1'b0;
    settle();
    check("raw_release", bus.instr_ready, 1);
    check("raw_sel1", bus.selector_out1, 8);
    check("raw_sel2", bus.selector_out2, 8);
    tick();
    bus.instr_valid = 1'b0;
    settle();
    check("add_valid", bus.dec_valid, 1);
    check("add_dest", bus.dec_dest, 9);
    check("add_writes", bus.dec_writes, 1);
    check("add_funct", bus.dec_funct, 6'h20);

    // set and retire of $8 in the same cycle
    bus.instr       = 32'h2008_0005;
    bus.instr_valid = 1'b1;
    bus.wb_valid    = 1'b1;
    bus.wb_dest     = 5'd8;
    settle();
    check("setclr_ready", bus.instr_ready, 1);
    tick();
    bus.wb_valid = 1'b0;
    bus.instr    = 32'h0108_4820;
    settle();
    check("setclr_stall", bus.instr_ready, 0);
    bus.instr_valid = 1'b0;
    bus.wb_valid    = 1'b1;
    bus.wb_dest     = 5'd8;
    tick();
    bus.wb_dest = 5'd9;
    tick();
    bus.wb_valid = 1'b0;
    settle();
    check("drained_valid", bus.dec_valid, 0);

    // ori $4,$0,0xFFFF with downstream stalled
    bus.dec_ready   = 1'b0;
    bus.instr       = 32'h3404_FFFF;
    bus.instr_valid = 1'b1;
    settle();
    check("ori_ready", bus.instr_ready, 1);
    tick();
    bus.instr = 32'h8FA4_FFFC;
    settle();
    check("ori_imm", bus.dec_imm, 32'h0000_FFFF);
    check("ori_dest", bus.dec_dest, 4);
    for (int i = 0; i < 3; i++) begin
      check("hold_ready", bus.instr_ready, 0);
      check("hold_valid", bus.dec_valid, 1);
      check("hold_sel1", bus.selector_out1, 0);
      check("hold_sel2", bus.selector_out2, 4);
      check("hold_imm", bus.dec_imm, 32'h0000_FFFF);
      tick();
    end
    bus.dec_ready = 1'b1;
    settle();
    check("lw_ready", bus.instr_ready, 1);
    check("lw_sel1", bus.selector_out1, 29);
    check("lw_sel2", bus.selector_out2, 4);
    tick();
    bus.instr = 32'h3C01_1234;
    settle();
    check("lw_valid", bus.dec_valid, 1);
    check("lw_imm", bus.dec_imm, 32'hFFFF_FFFC);
    check("lw_dest", bus.dec_dest, 4);
    check("lui_ready", bus.instr_ready, 1);
    tick();
    bus.instr = 32'h0C00_0010;
    settle();
    check("lui_valid", bus.dec_valid, 1);
    check("lui_imm", bus.dec_imm, 32'h1234_0000);
    check("lui_dest", bus.dec_dest, 1);
    tick();
    bus.instr = 32'hFC9F_0000;
    settle();
    check("jal_dest", bus.dec_dest, 31);
    check("jal_writes", bus.dec_writes, 1);
    check("jal_imm", bus.dec_imm, 32'h0000_0010);

    // illegal opcode with rs=$4, rt=$31 both pending
    check("ill_ready", bus.instr_ready, 1);
    tick();
    bus.instr = 32'h2000_0001;
    settle();
    check("ill_flag", bus.dec_illegal, 1);
    check("ill_writes", bus.dec_writes, 0);
    check("ill_dest", bus.dec_dest, 0);

    // addi $0,$0,1 never marks $0 pending
    tick();
    bus.instr = 32'h0000_4820;
    settle();
    check("zero_writes", bus.dec_writes, 0);
    check("zero_ill", bus.dec_illegal, 0);
    check("zero_ready", bus.instr_ready, 1);
    tick();

    // add $1,$1,$1 stalls, then reset clears the scoreboard
    bus.instr = 32'h0021_0820;
    settle();
    check("pre_rst_stall", bus.instr_ready, 0);
    bus.instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.instr_valid = 1'b1;
    settle();
    check("post_rst_valid", bus.dec_valid, 0);
    check("post_rst_ready", bus.instr_ready, 1);
    check("post_rst_dest", bus.dec_dest, 0);
    tick();
    bus.instr_valid = 1'b0;
    settle();
    check("post_rst_accept", bus.dec_dest, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
